// File: rtl/sdram_port_arb.sv
// sdram_port_arb: two-port request arbiter and in-order read-return router for one SDRAM user port.
// Latency: grant and controller command 1 cycle after request; read data 1 cycle after i_rd_valid.
// Backpressure: command held until i_ctrl_ready; reads (not writes) stall while the tag FIFO is full.
// Ports: i_a_* / i_b_*     requester inputs (req, we, addr, wdata)
//        o_a_* / o_b_*     grant pulse and routed read return (rvalid, rdata)
//        o_wr_* / o_rd_*   command to the controller, held until i_ctrl_ready
//        i_rd_valid/data   controller read return, in issue order; o_err_orphan sticky error
// Build option: define SDRAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority instead of round-robin.
module sdram_port_arb #(
   parameter int AddrWidth      = 13,
   parameter int DataWidth      = 16,
   parameter int MaxOutstanding = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_a_req,
   input  logic                 i_a_we,
   input  logic [AddrWidth-1:0] i_a_addr,
   input  logic [DataWidth-1:0] i_a_wdata,
   input  logic                 i_b_req,
   input  logic                 i_b_we,
   input  logic [AddrWidth-1:0] i_b_addr,
   input  logic [DataWidth-1:0] i_b_wdata,
   output logic                 o_a_gnt,
   output logic                 o_b_gnt,
   output logic                 o_a_rvalid,
   output logic                 o_b_rvalid,
   output logic [DataWidth-1:0] o_a_rdata,
   output logic [DataWidth-1:0] o_b_rdata,
   output logic                 o_wr_req,
   output logic [AddrWidth-1:0] o_wr_addr,
   output logic [DataWidth-1:0] o_wr_data,
   output logic                 o_rd_req,
   output logic [AddrWidth-1:0] o_rd_addr,
   input  logic                 i_ctrl_ready,
   input  logic                 i_rd_valid,
   input  logic [DataWidth-1:0] i_rd_data,
   output logic                 o_err_orphan
);

   localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam logic [PtrWidth:0]   CntOne  = 1;
   localparam logic [PtrWidth:0]   CntFull = (PtrWidth+1)'(MaxOutstanding);
   localparam logic [PtrWidth-1:0] PtrOne  = 1;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                    state;
   // Tag FIFO: one bit per outstanding read, 0 = port A, 1 = port B.
   logic [MaxOutstanding-1:0] tag_mem;
   logic [PtrWidth-1:0]       wr_ptr;
   logic [PtrWidth-1:0]       rd_ptr;
   logic [PtrWidth:0]         count;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
   logic                      last_b;
`endif

   logic tag_full;
   logic tag_empty;
   logic a_elig;
   logic b_elig;
   logic pick_b;
   logic do_grant;
   logic sel_we;
   logic do_push;
   logic do_pop;

   always_comb begin
      tag_full  = (count == CntFull);
      tag_empty = (count == '0);
      // A read needs a free tag slot; a write never does.
      a_elig    = i_a_req && (i_a_we || !tag_full);
      b_elig    = i_b_req && (i_b_we || !tag_full);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      pick_b    = b_elig && !a_elig;
`else
      pick_b    = b_elig && (!a_elig || !last_b);
`endif
      do_grant  = (state == IDLE) && (a_elig || b_elig);
      sel_we    = pick_b ? i_b_we : i_a_we;
      do_push   = do_grant && !sel_we;
      do_pop    = i_rd_valid && !tag_empty;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         o_a_gnt      <= 1'b0;
         o_b_gnt      <= 1'b0;
         o_a_rvalid   <= 1'b0;
         o_b_rvalid   <= 1'b0;
         o_a_rdata    <= '0;
         o_b_rdata    <= '0;
         o_wr_req     <= 1'b0;
         o_wr_addr    <= '0;
         o_wr_data    <= '0;
         o_rd_req     <= 1'b0;
         o_rd_addr    <= '0;
         o_err_orphan <= 1'b0;
         tag_mem      <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
         last_b       <= 1'b1;   // A wins the first contention after reset
`endif
      end else begin
         o_a_gnt    <= 1'b0;
         o_b_gnt    <= 1'b0;
         o_a_rvalid <= 1'b0;
         o_b_rvalid <= 1'b0;

         case (state)
            IDLE: begin
               if (do_grant) begin
                  o_a_gnt <= !pick_b;
                  o_b_gnt <= pick_b;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                  last_b  <= pick_b;
`endif
                  state   <= ISSUE;
                  if (sel_we) begin
                     o_wr_req  <= 1'b1;
                     o_wr_addr <= pick_b ? i_b_addr  : i_a_addr;
                     o_wr_data <= pick_b ? i_b_wdata : i_a_wdata;
                     o_rd_addr <= '0;
                  end else begin
                     o_rd_req  <= 1'b1;
                     o_rd_addr <= pick_b ? i_b_addr : i_a_addr;
                     o_wr_addr <= '0;
                     o_wr_data <= '0;
                  end
               end
            end
            ISSUE: begin
               if (i_ctrl_ready) begin
                  state     <= IDLE;
                  o_wr_req  <= 1'b0;
                  o_rd_req  <= 1'b0;
                  o_wr_addr <= '0;
                  o_wr_data <= '0;
                  o_rd_addr <= '0;
               end
            end
            default: state <= IDLE;
         endcase

         if (do_push) begin
            tag_mem[wr_ptr] <= pick_b;
            wr_ptr          <= wr_ptr + PtrOne;
         end

         if (do_pop) begin
            rd_ptr <= rd_ptr + PtrOne;
            if (tag_mem[rd_ptr]) begin
               o_b_rvalid <= 1'b1;
               o_b_rdata  <= i_rd_data;
            end else begin
               o_a_rvalid <= 1'b1;
               o_a_rdata  <= i_rd_data;
            end
         end else if (i_rd_valid) begin
            // Read data with nothing outstanding is dropped and flagged.
            o_err_orphan <= 1'b1;
         end

         // Simultaneous push and pop leave the occupancy unchanged.
         if (do_push && !do_pop) begin
            count <= count + CntOne;
         end else if (!do_push && do_pop) begin
            count <= count - CntOne;
         end
      end
   end

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb: scoreboard bench for sdram_port_arb with directed vectors.
// Stimulus pushes expected grant/read-return events; a negedge monitor pops and compares them.
// Direct checks cover reset values, stall hold, rdata hold and the sticky orphan flag.
module tb_sdram_port_arb;

   logic        clk;
   logic        i_rst_n;
   logic        a_req, a_we, b_req, b_we;
   logic [12:0] a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata;
   logic        o_a_gnt, o_b_gnt, o_a_rvalid, o_b_rvalid;
   logic [15:0] o_a_rdata, o_b_rdata;
   logic        o_wr_req, o_rd_req;
   logic [12:0] o_wr_addr, o_rd_addr;
   logic [15:0] o_wr_data;
   logic        ctrl_ready, rd_valid;
   logic [15:0] rd_data;
   logic        o_err_orphan;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // kind for grants: 0 A write, 1 A read, 2 B write, 3 B read; for returns: 0 A, 1 B
   typedef struct {
      int          kind;
      logic [15:0] addr;
      logic [15:0] data;
      int          cyc;
   } ev_t;

   ev_t gnt_q[$];
   ev_t rv_q[$];
   ev_t mg, me;

   sdram_port_arb #(.AddrWidth(13), .DataWidth(16), .MaxOutstanding(4)) dut (
      .i_clk        (clk),
      .i_rst_n      (i_rst_n),
      .i_a_req      (a_req),
      .i_a_we       (a_we),
      .i_a_addr     (a_addr),
      .i_a_wdata    (a_wdata),
      .i_b_req      (b_req),
      .i_b_we       (b_we),
      .i_b_addr     (b_addr),
      .i_b_wdata    (b_wdata),
      .o_a_gnt      (o_a_gnt),
      .o_b_gnt      (o_b_gnt),
      .o_a_rvalid   (o_a_rvalid),
      .o_b_rvalid   (o_b_rvalid),
      .o_a_rdata    (o_a_rdata),
      .o_b_rdata    (o_b_rdata),
      .o_wr_req     (o_wr_req),
      .o_wr_addr    (o_wr_addr),
      .o_wr_data    (o_wr_data),
      .o_rd_req     (o_rd_req),
      .o_rd_addr    (o_rd_addr),
      .i_ctrl_ready (ctrl_ready),
      .i_rd_valid   (rd_valid),
      .i_rd_data    (rd_data),
      .o_err_orphan (o_err_orphan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic ev_t mk(input int kind, input logic [12:0] addr, input logic [15:0] data,
                              input int c);
      ev_t e;
      e.kind = kind;
      e.addr = {3'b000, addr};
      e.data = data;
      e.cyc  = c;
      return e;
   endfunction

   // Monitor: outputs sampled on the falling edge, compared against the scoreboard queues.
   always @(negedge clk) begin
      if (o_a_gnt || o_b_gnt) begin
         if (o_a_gnt && o_b_gnt)          mg.kind = 8;
         else if (o_wr_req && !o_rd_req)  mg.kind = o_b_gnt ? 2 : 0;
         else if (o_rd_req && !o_wr_req)  mg.kind = o_b_gnt ? 3 : 1;
         else                             mg.kind = 9;
         mg.addr = o_wr_req ? {3'b000, o_wr_addr} : {3'b000, o_rd_addr};
         mg.data = o_wr_req ? o_wr_data : 16'h0000;
         mg.cyc  = cyc;
         if (gnt_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL gnt_unexpected: got kind %0d addr %0h at cycle %0d, required none",
                     mg.kind, mg.addr, cyc);
         end else begin
            me = gnt_q.pop_front();
            chk("gnt_kind", mg.kind, me.kind);
            chk("gnt_addr", {16'h0, mg.addr}, {16'h0, me.addr});
            chk("gnt_data", {16'h0, mg.data}, {16'h0, me.data});
            chk("gnt_cycle", mg.cyc, me.cyc);
         end
      end
      if (o_a_rvalid || o_b_rvalid) begin
         mg.kind = (o_a_rvalid && o_b_rvalid) ? 8 : (o_b_rvalid ? 1 : 0);
         mg.data = o_b_rvalid ? o_b_rdata : o_a_rdata;
         mg.cyc  = cyc;
         if (rv_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rvalid_unexpected: got port %0d data %0h at cycle %0d, required none",
                     mg.kind, mg.data, cyc);
         end else begin
            me = rv_q.pop_front();
            chk("rv_port", mg.kind, me.kind);
            chk("rv_data", {16'h0, mg.data}, {16'h0, me.data});
            chk("rv_cycle", mg.cyc, me.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single request from an idle arbiter: granted next cycle, request dropped in the grant cycle.
   task automatic do_req(input bit port_b, input bit we, input logic [12:0] addr,
                         input logic [15:0] data);
      if (port_b) begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
      end else begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
      end
      gnt_q.push_back(mk((port_b ? 2 : 0) + (we ? 0 : 1), addr, we ? data : 16'h0000, cyc + 1));
      tick();
      a_req = 1'b0;
      b_req = 1'b0;
      tick();
   endtask

   task automatic rd_return(input bit port_b, input logic [15:0] data);
      rd_valid = 1'b1;
      rd_data  = data;
      rv_q.push_back(mk(port_b ? 1 : 0, 13'h0, data, cyc + 1));
      tick();
      rd_valid = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_flags"}, {o_a_gnt, o_b_gnt, o_a_rvalid, o_b_rvalid, o_wr_req, o_rd_req}, 0);
      chk({tag, "_a_rdata"}, o_a_rdata, 0);
      chk({tag, "_b_rdata"}, o_b_rdata, 0);
      chk({tag, "_wr_addr"}, o_wr_addr, 0);
      chk({tag, "_rd_addr"}, o_rd_addr, 0);
      chk({tag, "_wr_data"}, o_wr_data, 0);
      chk({tag, "_orphan"}, o_err_orphan, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b0; ctrl_ready = 1'b1; rd_valid = 1'b0; rd_data = '0;
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      chk_reset("reset");
      i_rst_n = 1'b1;
      tick();

      // Single write; back to idle two cycles after the request
      do_req(1'b0, 1'b1, 13'h0123, 16'hBEEF);
      @(negedge clk);
      chk("idle_wr_req", o_wr_req, 0);

      // Contention: both ports hold writes; A was granted last, so B goes first
      tick();
      a_req = 1'b1; a_we = 1'b1; a_addr = 13'h100; a_wdata = 16'hA000;
      b_req = 1'b1; b_we = 1'b1; b_addr = 13'h200; b_wdata = 16'hB000;
      for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
         gnt_q.push_back(mk(0, 13'h100, 16'hA000, cyc + 1 + 2 * i));
`else
         if (i % 2 == 0) gnt_q.push_back(mk(2, 13'h200, 16'hB000, cyc + 1 + 2 * i));
         else            gnt_q.push_back(mk(0, 13'h100, 16'hA000, cyc + 1 + 2 * i));
`endif
      end
      repeat (8) tick();
      a_req = 1'b0;
      b_req = 1'b0;
      tick();

      // Read routing in issue order
      do_req(1'b1, 1'b0, 13'h010, 16'h0);
      do_req(1'b0, 1'b0, 13'h020, 16'h0);
      do_req(1'b1, 1'b0, 13'h030, 16'h0);
      rd_return(1'b1, 16'h1111);
      rd_return(1'b0, 16'h2222);
      rd_return(1'b1, 16'h3333);
      tick();
      @(negedge clk);
      chk("hold_a_rdata", o_a_rdata, 16'h2222);
      chk("hold_b_rdata", o_b_rdata, 16'h3333);

      // Tag FIFO full: B read blocked, A write still granted; one return frees a slot
      tick();
      do_req(1'b0, 1'b0, 13'h040, 16'h0);
      do_req(1'b0, 1'b0, 13'h041, 16'h0);
      do_req(1'b0, 1'b0, 13'h042, 16'h0);
      do_req(1'b0, 1'b0, 13'h043, 16'h0);
      b_req = 1'b1; b_we = 1'b0; b_addr = 13'h050;
      a_req = 1'b1; a_we = 1'b1; a_addr = 13'h060; a_wdata = 16'hC0DE;
      gnt_q.push_back(mk(0, 13'h060, 16'hC0DE, cyc + 1));
      tick();
      a_req = 1'b0;
      tick();
      tick();
      tick();
      rd_valid = 1'b1; rd_data = 16'h4444;
      rv_q.push_back(mk(0, 13'h0, 16'h4444, cyc + 1));
      gnt_q.push_back(mk(3, 13'h050, 16'h0, cyc + 2));
      tick();
      rd_valid = 1'b0;
      tick();
      b_req = 1'b0;
      tick();
      rd_return(1'b0, 16'h4001);
      rd_return(1'b0, 16'h4002);
      rd_return(1'b0, 16'h4003);
      rd_return(1'b1, 16'h4004);
      tick();

      // Stall: ready low for 5 cycles holds the read command; B write waits
      ctrl_ready = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 13'h077;
      b_req = 1'b1; b_we = 1'b1; b_addr = 13'h0B0; b_wdata = 16'h5A5A;
      gnt_q.push_back(mk(1, 13'h077, 16'h0, cyc + 1));
      gnt_q.push_back(mk(2, 13'h0B0, 16'h5A5A, cyc + 7));
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i == 1) a_req = 1'b0;
         if (i == 5) ctrl_ready = 1'b1;
         @(negedge clk);
         chk("stall_rd_req", o_rd_req, 1);
         chk("stall_rd_addr", o_rd_addr, 13'h077);
      end
      tick();
      tick();
      b_req = 1'b0;
      tick();
      rd_return(1'b0, 16'h7777);
      tick();

      // Reset during ISSUE with two reads outstanding; the late return is an orphan
      do_req(1'b0, 1'b0, 13'h081, 16'h0);
      do_req(1'b1, 1'b0, 13'h082, 16'h0);
      ctrl_ready = 1'b0;
      a_req = 1'b1; a_we = 1'b1; a_addr = 13'h083; a_wdata = 16'h1234;
      gnt_q.push_back(mk(0, 13'h083, 16'h1234, cyc + 1));
      tick();
      a_req = 1'b0;
      tick();
      i_rst_n = 1'b0;
      tick();
      @(negedge clk);
      chk_reset("midrst");
      i_rst_n = 1'b1;
      ctrl_ready = 1'b1;
      tick();
      rd_valid = 1'b1; rd_data = 16'h9999;
      tick();
      rd_valid = 1'b0;
      @(negedge clk);
      chk("orphan_set", o_err_orphan, 1);
      chk("orphan_rvalid", {o_a_rvalid, o_b_rvalid}, 0);
      chk("orphan_a_rdata", o_a_rdata, 0);
      chk("orphan_b_rdata", o_b_rdata, 0);

      // Pointer back at B after reset: A wins contention
      a_req = 1'b1; a_we = 1'b1; a_addr = 13'h0AA; a_wdata = 16'h0A0A;
      b_req = 1'b1; b_we = 1'b1; b_addr = 13'h0BB; b_wdata = 16'h0B0B;
      gnt_q.push_back(mk(0, 13'h0AA, 16'h0A0A, cyc + 1));
      tick();
      a_req = 1'b0;
      b_req = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("orphan_sticky", o_err_orphan, 1);
      chk("gnt_q_drained", gnt_q.size(), 0);
      chk("rv_q_drained", rv_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
